cmp_minmax_ctrl: RTL and testbench



---
 rtl/cmp_minmax_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_cmp_minmax_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_minmax_ctrl.sv
// ============================================================================
// cmp_minmax_ctrl
// ----------------------------------------------------------------------------
// Streams a burst of signed W-bit samples through a single subtract-based
// comparator and keeps a running minimum and maximum of the burst.
//
// The comparator computes D = X - Y and derives the flags Z (D == 0),
// N (sign of D) and V (signed overflow of X - Y). It is shared in time:
// in CMP_MIN it compares the sample against the current minimum, and in
// CMP_MAX against the current maximum. Ordering uses N^V, so the result
// stays correct even when the subtraction overflows.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start_i      in   begin a burst (only looked at in IDLE)
//   len_i        in   burst length, captured together with start_i
//   in_valid_i   in   source presents a sample
//   in_ready_o   out  block takes a sample this cycle (ACCEPT only)
//   in_data_i    in   signed sample
//   busy_o       out  high in every state except IDLE
//   done_o       out  one-cycle pulse, results valid in that cycle
//   min_out_o    out  running / final minimum
//   max_out_o    out  running / final maximum
//   count_out_o  out  samples accepted in the current burst
//   ovf_seen_o   out  sticky: some comparison in this burst overflowed
// ============================================================================
module cmp_minmax_ctrl #(
    parameter int W     = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W-1:0]     in_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [W-1:0]     min_out_o,
    output logic [W-1:0]     max_out_o,
    output logic [CNT_W-1:0] count_out_o,
    output logic             ovf_seen_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACCEPT  = 3'd1,
        S_CMP_MIN = 3'd2,
        S_CMP_MAX = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] len_q,    len_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [W-1:0]     sample_q, sample_d;
    logic [W-1:0]     min_q,    min_d;
    logic [W-1:0]     max_q,    max_d;
    logic             ovf_q,    ovf_d;

    // Handshake only exists while in ACCEPT.
    logic hs;
    assign hs = (state_q == S_ACCEPT) && in_valid_i;

    // ------------------------------------------------------------------
    // Shared comparator: X is always the held sample, Y is selected by
    // which comparison phase we are in.
    // ------------------------------------------------------------------
    logic [W-1:0] cmp_x;
    logic [W-1:0] cmp_y;
    logic [W-1:0] cmp_d;
    logic         cmp_z;
    logic         cmp_n;
    logic         cmp_v;
    logic         cmp_lt;
    logic         cmp_gt;

    assign cmp_x = sample_q;
    assign cmp_y = (state_q == S_CMP_MAX) ? max_q : min_q;
    assign cmp_d = cmp_x - cmp_y;
    assign cmp_z = (cmp_d == '0);
    assign cmp_n = cmp_d[W-1];
    // Subtraction overflows when the operands differ in sign and the
    // result's sign differs from the minuend's sign.
    assign cmp_v = (cmp_x[W-1] != cmp_y[W-1]) && (cmp_d[W-1] != cmp_x[W-1]);
    assign cmp_lt = cmp_n ^ cmp_v;
    assign cmp_gt = !(cmp_n ^ cmp_v) && !cmp_z;

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (len_i == '0) ? S_DONE : S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (hs) begin
                    if (cnt_q == '0) begin
                        // First sample only seeds min/max; no compare needed.
                        state_d = (len_q == CNT_W'(1)) ? S_DONE : S_ACCEPT;
                    end else begin
                        state_d = S_CMP_MIN;
                    end
                end
            end
            S_CMP_MIN: begin
                state_d = S_CMP_MAX;
            end
            S_CMP_MAX: begin
                // cnt_q already includes the sample just compared.
                state_d = (cnt_q == len_q) ? S_DONE : S_ACCEPT;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        in_ready_o = 1'b0;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        case (state_q)
            S_IDLE:   busy_o     = 1'b0;
            S_ACCEPT: in_ready_o = 1'b1;
            S_DONE:   done_o     = 1'b1;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        len_d    = len_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        min_d    = min_q;
        max_d    = max_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    len_d = len_i;
                    cnt_d = '0;
                    min_d = '0;
                    max_d = '0;
                    ovf_d = 1'b0;
                end
            end
            S_ACCEPT: begin
                if (hs) begin
                    sample_d = in_data_i;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == '0) begin
                        min_d = in_data_i;
                        max_d = in_data_i;
                    end
                end
            end
            S_CMP_MIN: begin
                if (cmp_lt) begin
                    min_d = sample_q;
                end
                ovf_d = ovf_q | cmp_v;
            end
            S_CMP_MAX: begin
                if (cmp_gt) begin
                    max_d = sample_q;
                end
                ovf_d = ovf_q | cmp_v;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            min_q    <= '0;
            max_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            min_q    <= min_d;
            max_q    <= max_d;
            ovf_q    <= ovf_d;
        end
    end

    assign min_out_o   = min_q;
    assign max_out_o   = max_q;
    assign count_out_o = cnt_q;
    assign ovf_seen_o  = ovf_q;

endmodule

// File: tb/tb_cmp_minmax_ctrl.sv
module tb_cmp_minmax_ctrl;

    localparam int W     = 4;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             start_i;
    logic [CNT_W-1:0] len_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [W-1:0]     in_data_i;
    logic             busy_o;
    logic             done_o;
    logic [W-1:0]     min_out_o;
    logic [W-1:0]     max_out_o;
    logic [CNT_W-1:0] count_out_o;
    logic             ovf_seen_o;

    int total;
    int bad;

    cmp_minmax_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .len_i       (len_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .min_out_o   (min_out_o),
        .max_out_o   (max_out_o),
        .count_out_o (count_out_o),
        .ovf_seen_o  (ovf_seen_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One burst: samples packed 4 bits each, sample 0 in the low nibble.
    typedef struct {
        int         len;
        logic [15:0] samples;
        int         stall_idx;   // sample index before which the source stalls
        int         stall_n;     // stall length in ACCEPT cycles (0 = none)
        bit         poke_start;  // pulse start while busy
        logic [3:0] emin;
        logic [3:0] emax;
        int         ecnt;
        bit         eovf;
        int         edone;       // cycle of done, start edge = cycle 0
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int         idx;
        int         stall_left;
        bit         stalling;
        int         got_done;
        logic [3:0] snap_min, snap_max;
        logic [3:0] snap_cnt;
        logic [3:0] r_min, r_max;
        logic [3:0] r_cnt;
        logic       r_ovf;
        logic [15:0] smp;

        smp        = v.samples;
        idx        = 0;
        stall_left = v.stall_n;
        stalling   = 1'b0;
        got_done   = -1;
        snap_min   = '0;
        snap_max   = '0;
        snap_cnt   = '0;
        r_min      = '0;
        r_max      = '0;
        r_cnt      = '0;
        r_ovf      = 1'b0;

        @(negedge clk);
        start_i    = 1'b1;
        len_i      = CNT_W'(v.len);
        in_valid_i = 1'b0;

        for (int cyc = 1; cyc < 200; cyc++) begin
            @(negedge clk);
            if (v.poke_start && cyc == 2) begin
                start_i = 1'b1;
                len_i   = CNT_W'(1);
            end else begin
                start_i = 1'b0;
            end
            if (done_o) begin
                got_done = cyc;
                r_min    = min_out_o;
                r_max    = max_out_o;
                r_cnt    = count_out_o;
                r_ovf    = ovf_seen_o;
                in_valid_i = 1'b0;
                break;
            end
            if (stalling) begin
                check($sformatf("v%0d stall_ready", id), int'(in_ready_o), 1);
                check($sformatf("v%0d stall_min", id), int'(min_out_o), int'(snap_min));
                check($sformatf("v%0d stall_max", id), int'(max_out_o), int'(snap_max));
                check($sformatf("v%0d stall_cnt", id), int'(count_out_o), int'(snap_cnt));
            end
            if (in_ready_o && idx == v.stall_idx && stall_left > 0) begin
                if (!stalling) begin
                    snap_min = min_out_o;
                    snap_max = max_out_o;
                    snap_cnt = count_out_o;
                end
                stalling   = 1'b1;
                stall_left--;
                in_valid_i = 1'b0;
            end else if (in_ready_o && idx < v.len) begin
                stalling   = 1'b0;
                in_valid_i = 1'b1;
                in_data_i  = smp[4*idx +: 4];
                idx++;
            end else begin
                stalling   = 1'b0;
                in_valid_i = 1'b0;
            end
        end
        start_i = 1'b0;

        check($sformatf("v%0d done_cycle", id), got_done, v.edone);
        check($sformatf("v%0d min", id), int'(r_min), int'(v.emin));
        check($sformatf("v%0d max", id), int'(r_max), int'(v.emax));
        check($sformatf("v%0d count", id), int'(r_cnt), v.ecnt);
        check($sformatf("v%0d ovf", id), int'(r_ovf), int'(v.eovf));

        @(negedge clk);
        check($sformatf("v%0d done_pulse", id), int'(done_o), 0);
        check($sformatf("v%0d busy_after", id), int'(busy_o), 0);
        check($sformatf("v%0d min_hold", id), int'(min_out_o), int'(v.emin));
        $display("burst v%0d len=%0d done@%0d min=%h max=%h cnt=%0d ovf=%0d",
                 id, v.len, got_done, r_min, r_max, r_cnt, r_ovf);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, int'(in_ready_o), 0);
        check({tag, "_busy"}, int'(busy_o), 0);
        check({tag, "_done"}, int'(done_o), 0);
        check({tag, "_min"}, int'(min_out_o), 0);
        check({tag, "_max"}, int'(max_out_o), 0);
        check({tag, "_cnt"}, int'(count_out_o), 0);
        check({tag, "_ovf"}, int'(ovf_seen_o), 0);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        start_i    = 1'b0;
        len_i      = '0;
        in_valid_i = 1'b0;
        in_data_i  = '0;

        //          len samples   stl_i stl_n poke  min    max    cnt ovf done
        vecs[0] = '{4, 16'h7824, 0,   0,    1'b0, 4'h8, 4'h7, 4,  1'b1, 11};
        vecs[1] = '{0, 16'h0000, 0,   0,    1'b0, 4'h0, 4'h0, 0,  1'b0, 1};
        vecs[2] = '{3, 16'h0444, 0,   0,    1'b0, 4'h4, 4'h4, 3,  1'b0, 8};
        vecs[3] = '{1, 16'h000B, 0,   0,    1'b0, 4'hB, 4'hB, 1,  1'b0, 2};
        vecs[4] = '{4, 16'hE5F3, 2,   5,    1'b0, 4'hE, 4'h5, 4,  1'b0, 16};
        vecs[5] = '{2, 16'h006D, 0,   0,    1'b1, 4'hD, 4'h6, 2,  1'b1, 5};
        vecs[6] = '{3, 16'h0991, 0,   0,    1'b0, 4'h9, 4'h1, 3,  1'b0, 8};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset during CMP_MIN: len=3, samples 5, -4, 2.
        @(negedge clk);
        start_i = 1'b1;
        len_i   = CNT_W'(3);
        @(negedge clk);                 // cycle 1: ACCEPT, offer first sample
        start_i    = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = 4'h5;
        @(negedge clk);                 // cycle 2: ACCEPT, offer second sample
        in_data_i  = 4'hC;
        @(negedge clk);                 // cycle 3: CMP_MIN
        in_valid_i = 1'b0;
        check("rst_mid_busy", int'(busy_o), 1);
        check("rst_mid_ready", int'(in_ready_o), 0);
        check("rst_mid_cnt", int'(count_out_o), 2);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        $display("reset asserted during CMP_MIN, outputs cleared");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_hold_done", int'(done_o), 0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rst_release_done", int'(done_o), 0);
            check("rst_release_busy", int'(busy_o), 0);
        end

        run_vec(6, vecs[6]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
